// File: rtl/cube_pkg.sv
// Shared types and constants for the cube move scheduler and its move queue.
package cube_pkg;

  localparam int MOVE_W_DEF = 8;
  localparam int DEPTH_DEF  = 8;

  localparam logic [MOVE_W_DEF-1:0] MOVE_NONE = '0;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_DONE
  } sched_state_t;

  // Occupancy counter width: must be able to hold DEPTH itself, not just DEPTH-1.
  function automatic int cnt_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/move_scheduler_if.sv
// Move-source, datapath and status signals of the move scheduler, bundled as one interface.
interface move_scheduler_if
  import cube_pkg::*;
#(
  parameter int DEPTH  = DEPTH_DEF,
  parameter int MOVE_W = MOVE_W_DEF
);

  localparam int CNT_W = cnt_width(DEPTH);

  logic              clear;
  logic              key_valid;
  logic [MOVE_W-1:0] key_code;
  logic              key_drop;
  logic              seq_valid;
  logic [MOVE_W-1:0] seq_code;
  logic              seq_ready;
  logic              move_f;
  logic [MOVE_W-1:0] move_code;
  logic              rot_done;
  logic              busy;
  logic [CNT_W-1:0]  q_count;
  logic [15:0]       move_count;

  // The master side is whoever drives moves in and completes rotations.
  modport master (
    output clear, key_valid, key_code, seq_valid, seq_code, rot_done,
    input  key_drop, seq_ready, move_f, move_code, busy, q_count, move_count
  );

  modport slave (
    input  clear, key_valid, key_code, seq_valid, seq_code, rot_done,
    output key_drop, seq_ready, move_f, move_code, busy, q_count, move_count
  );

endinterface

// File: rtl/move_fifo.sv
// Synchronous move queue with flush; full/empty come from the registered occupancy.
module move_fifo #(
  parameter  int DEPTH = 8,
  parameter  int W     = 8,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             Reset,
  input  logic             clear,
  input  logic             push,
  input  logic [W-1:0]     push_data,
  input  logic             pop,
  output logic [W-1:0]     head,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign head    = mem[rd_ptr];
  assign do_push = push && !full && !clear;
  assign do_pop  = pop && !empty && !clear;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/move_scheduler.sv
// Arbitrates keyboard and sequence moves into a queue and issues them one at a time
// to the rotation datapath, waiting for rot_done between moves.
module move_scheduler
  import cube_pkg::*;
#(
  parameter int DEPTH  = DEPTH_DEF,
  parameter int MOVE_W = MOVE_W_DEF
) (
  input logic            clk,
  input logic            Reset,
  move_scheduler_if.slave bus
);

  localparam int                CNT_W   = cnt_width(DEPTH);
  localparam logic [MOVE_W-1:0] NO_MOVE = MOVE_W'(MOVE_NONE);

  sched_state_t      state;
  sched_state_t      state_next;
  logic [MOVE_W-1:0] hold_code;
  logic [MOVE_W-1:0] head_code;
  logic [MOVE_W-1:0] push_data;
  logic [CNT_W-1:0]  fifo_count;
  logic [15:0]       move_count;
  logic              fifo_full;
  logic              fifo_empty;
  logic              key_push;
  logic              seq_push;
  logic              seq_ready;
  logic              push;
  logic              pop;
  logic              count_done;
  logic              key_drop;
  logic              key_drop_next;
  logic              move_f;
  logic [MOVE_W-1:0] move_code;
  logic              busy;

  // Keyboard always wins; zero codes complete their handshake but never enter the queue.
  assign seq_ready     = !Reset && !fifo_full && !bus.key_valid && !bus.clear;
  assign key_push      = bus.key_valid && !fifo_full && !bus.clear && (bus.key_code != NO_MOVE);
  assign seq_push      = bus.seq_valid && seq_ready && (bus.seq_code != NO_MOVE);
  assign push          = key_push || seq_push;
  assign push_data     = bus.key_valid ? bus.key_code : bus.seq_code;
  assign key_drop_next = bus.key_valid && fifo_full && !bus.clear && (bus.key_code != NO_MOVE);

  move_fifo #(
    .DEPTH (DEPTH),
    .W     (MOVE_W)
  ) u_fifo (
    .clk       (clk),
    .Reset     (Reset),
    .clear     (bus.clear),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .head      (head_code),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      state      <= IDLE;
      hold_code  <= NO_MOVE;
      move_count <= '0;
      key_drop   <= 1'b0;
    end else begin
      state    <= state_next;
      key_drop <= key_drop_next;
      if (pop)        hold_code  <= head_code;
      if (count_done) move_count <= move_count + 16'd1;
    end
  end

  // A flush cycle must not pop, otherwise a move meant to be discarded would still be issued.
  always_comb begin
    state_next = state;
    pop        = 1'b0;
    count_done = 1'b0;
    move_f     = 1'b0;
    move_code  = NO_MOVE;
    busy       = 1'b0;
    case (state)
      IDLE: begin
        if (!fifo_empty && !bus.clear) begin
          pop        = 1'b1;
          state_next = ISSUE;
        end
      end
      ISSUE: begin
        move_f     = 1'b1;
        move_code  = hold_code;
        busy       = 1'b1;
        state_next = WAIT_DONE;
      end
      WAIT_DONE: begin
        busy = 1'b1;
        if (bus.rot_done) begin
          count_done = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign bus.seq_ready  = seq_ready;
  assign bus.key_drop   = key_drop;
  assign bus.move_f     = move_f;
  assign bus.move_code  = move_code;
  assign bus.busy       = busy;
  assign bus.q_count    = fifo_count;
  assign bus.move_count = move_count;

endmodule

// File: tb/tb_move_scheduler.sv
// Bench for move_scheduler: a queue-based model checked every cycle plus directed scenarios
// with hand-computed expectations on issue order, latency, drops, flush and reset.
module tb_move_scheduler;
  import cube_pkg::*;

  localparam int DEPTH  = 8;
  localparam int MOVE_W = 8;

  logic clk   = 1'b0;
  logic Reset = 1'b1;
  always #5 clk = ~clk;

  move_scheduler_if #(.DEPTH(DEPTH), .MOVE_W(MOVE_W)) bus ();

  move_scheduler #(.DEPTH(DEPTH), .MOVE_W(MOVE_W)) dut (
    .clk   (clk),
    .Reset (Reset),
    .bus   (bus.slave)
  );

  int  n_assert = 0;
  int  n_fail   = 0;
  bit  chk_en   = 1'b0;
  int  issued[$];
  int  expq[$];
  int  drop_pulses = 0;
  bit  acc;

  int  model_q[$];
  bit  m_flying, m_strobe, m_drop, m_was_strobe, m_full;
  int  m_code, m_count;

  task automatic checkOutput(input string name, input int actual, input int expected);
    n_assert++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic checkIssued(input string name);
    checkOutput({name, "_len"}, issued.size(), expq.size());
    foreach (expq[i])
      checkOutput($sformatf("%s_%0d", name, i), (i < issued.size()) ? issued[i] : -1, expq[i]);
  endtask

  task automatic applyStimulus(input bit kv, input logic [7:0] kc, input bit sv,
                               input logic [7:0] sc, input bit rd, input bit clr,
                               output bit seq_acc);
    bus.key_valid = kv;
    bus.key_code  = kc;
    bus.seq_valid = sv;
    bus.seq_code  = sc;
    bus.rot_done  = rd;
    bus.clear     = clr;
    @(negedge clk);
    seq_acc = bus.seq_valid && bus.seq_ready;
    @(posedge clk);
    #1;
  endtask

  // Completes each move in its first waiting cycle until nothing is queued or in flight.
  task automatic drainAll(input int budget);
    int n = 0;
    bit a;
    while ((bus.busy || bus.q_count != 0) && n < budget) begin
      applyStimulus(1'b0, 8'h00, 1'b0, 8'h00, bus.busy && !bus.move_f, 1'b0, a);
      n++;
    end
    checkOutput("drain_in_budget", int'(n < budget), 1);
  endtask

  // Model: a queue of codes plus one in-flight move that strobes once, then waits for rot_done.
  always @(posedge clk or posedge Reset) begin
    if (Reset) begin
      model_q.delete();
      m_flying = 1'b0;
      m_strobe = 1'b0;
      m_drop   = 1'b0;
      m_code   = 0;
      m_count  = 0;
    end else begin
      m_full       = (model_q.size() == DEPTH);
      m_was_strobe = m_strobe;
      m_strobe     = 1'b0;
      if (!m_flying && model_q.size() != 0 && !bus.clear) begin
        m_code   = model_q.pop_front();
        m_flying = 1'b1;
        m_strobe = 1'b1;
      end else if (m_flying && !m_was_strobe && bus.rot_done) begin
        m_flying = 1'b0;
        m_count  = (m_count + 1) % 65536;
      end
      m_drop = bus.key_valid && m_full && !bus.clear && (bus.key_code != 0);
      if (bus.clear)
        model_q.delete();
      else if (bus.key_valid) begin
        if (!m_full && bus.key_code != 0) model_q.push_back(int'(bus.key_code));
      end else if (bus.seq_valid && !m_full && bus.seq_code != 0)
        model_q.push_back(int'(bus.seq_code));
    end
  end

  always @(negedge clk) begin
    if (chk_en && !Reset) begin
      checkOutput("move_f",     int'(bus.move_f),     int'(m_strobe));
      checkOutput("move_code",  int'(bus.move_code),  m_strobe ? m_code : 0);
      checkOutput("busy",       int'(bus.busy),       int'(m_flying));
      checkOutput("q_count",    int'(bus.q_count),    model_q.size());
      checkOutput("move_count", int'(bus.move_count), m_count);
      checkOutput("key_drop",   int'(bus.key_drop),   int'(m_drop));
      checkOutput("seq_ready",  int'(bus.seq_ready),
                  int'(model_q.size() < DEPTH && !bus.key_valid && !bus.clear));
      if (bus.move_f)   issued.push_back(int'(bus.move_code));
      if (bus.key_drop) drop_pulses++;
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, n_fail=%0d", n_fail);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int  k, guard;
    bit  kv;
    bus.key_valid = 1'b0;
    bus.key_code  = 8'h00;
    bus.seq_valid = 1'b0;
    bus.seq_code  = 8'h00;
    bus.rot_done  = 1'b0;
    bus.clear     = 1'b0;
    Reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_move_f",     int'(bus.move_f),     0);
    checkOutput("rst_move_code",  int'(bus.move_code),  0);
    checkOutput("rst_busy",       int'(bus.busy),       0);
    checkOutput("rst_q_count",    int'(bus.q_count),    0);
    checkOutput("rst_move_count", int'(bus.move_count), 0);
    checkOutput("rst_key_drop",   int'(bus.key_drop),   0);
    checkOutput("rst_seq_ready",  int'(bus.seq_ready),  0);
    Reset  = 1'b0;
    chk_en = 1'b1;

    $display("[TB] single key latency");
    issued.delete();
    applyStimulus(1'b1, 8'h1D, 1'b0, 8'h00, 1'b0, 1'b0, acc);
    checkOutput("t1_busy_c1", int'(bus.busy), 0);
    applyStimulus(1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, acc);
    checkOutput("t1_move_f_c2",    int'(bus.move_f),    1);
    checkOutput("t1_move_code_c2", int'(bus.move_code), 8'h1D);
    repeat (4) applyStimulus(1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, acc);
    checkOutput("t1_busy_c6", int'(bus.busy), 1);
    applyStimulus(1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, acc);
    checkOutput("t1_busy_c7",       int'(bus.busy),       0);
    checkOutput("t1_move_count_c7", int'(bus.move_count), 1);

    $display("[TB] keyboard priority");
    issued.delete();
    applyStimulus(1'b1, 8'h15, 1'b1, 8'h2B, 1'b0, 1'b0, acc);
    checkOutput("t2_seq_blocked", int'(acc), 0);
    applyStimulus(1'b0, 8'h00, 1'b1, 8'h2B, 1'b0, 1'b0, acc);
    checkOutput("t2_seq_accepted", int'(acc), 1);
    drainAll(40);
    expq.delete();
    expq.push_back(8'h15);
    expq.push_back(8'h2B);
    checkIssued("t2_order");

    $display("[TB] overflow with stalled datapath");
    issued.delete();
    drop_pulses = 0;
    for (int i = 0; i < 10; i++)
      applyStimulus(1'b1, 8'(8'h31 + i), 1'b0, 8'h00, 1'b0, 1'b0, acc);
    checkOutput("t3_q_full", int'(bus.q_count), 8);
    checkOutput("t3_busy",   int'(bus.busy),    1);
    drainAll(100);
    checkOutput("t3_drop_pulses", drop_pulses, 1);
    expq.delete();
    for (int i = 0; i < 9; i++) expq.push_back(8'h31 + i);
    checkIssued("t3_order");

    $display("[TB] sequence stream with zero keys");
    issued.delete();
    k = 0;
    guard = 0;
    while (k < 3 && guard < 30) begin
      kv = (guard % 2 == 0);
      applyStimulus(kv, MOVE_NONE, 1'b1, 8'(8'h41 + k), 1'b0, 1'b0, acc);
      if (acc) k++;
      guard++;
    end
    checkOutput("t4_seq_all_taken", k, 3);
    drainAll(60);
    expq.delete();
    for (int i = 0; i < 3; i++) expq.push_back(8'h41 + i);
    checkIssued("t4_order");

    $display("[TB] flush during wait");
    issued.delete();
    for (int i = 0; i < 6; i++)
      applyStimulus(1'b1, 8'(8'h51 + i), 1'b0, 8'h00, 1'b0, 1'b0, acc);
    checkOutput("t5_q_before",     int'(bus.q_count),    5);
    checkOutput("t5_count_before", int'(bus.move_count), 15);
    applyStimulus(1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1, acc);
    checkOutput("t5_q_after_clear", int'(bus.q_count), 0);
    checkOutput("t5_busy_kept",     int'(bus.busy),    1);
    applyStimulus(1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, acc);
    applyStimulus(1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, acc);
    checkOutput("t5_count_after", int'(bus.move_count), 16);
    repeat (4) applyStimulus(1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, acc);
    checkOutput("t5_idle", int'(bus.busy), 0);
    expq.delete();
    expq.push_back(8'h51);
    checkIssued("t5_only_inflight");

    $display("[TB] stray rot_done and reset mid-move");
    applyStimulus(1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, acc);
    checkOutput("t6_stray_done", int'(bus.move_count), 16);
    applyStimulus(1'b1, 8'h61, 1'b0, 8'h00, 1'b0, 1'b0, acc);
    applyStimulus(1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, acc);
    applyStimulus(1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, acc);
    checkOutput("t6_waiting", int'(bus.busy), 1);
    #2 Reset = 1'b1;
    #1;
    checkOutput("t6_rst_move_f",     int'(bus.move_f),     0);
    checkOutput("t6_rst_busy",       int'(bus.busy),       0);
    checkOutput("t6_rst_q_count",    int'(bus.q_count),    0);
    checkOutput("t6_rst_move_count", int'(bus.move_count), 0);
    checkOutput("t6_rst_key_drop",   int'(bus.key_drop),   0);
    checkOutput("t6_rst_seq_ready",  int'(bus.seq_ready),  0);
    @(posedge clk);
    #1;
    Reset = 1'b0;
    issued.delete();
    repeat (3) applyStimulus(1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, acc);
    checkOutput("t6_no_strobe",   issued.size(),        0);
    checkOutput("t6_count_after", int'(bus.move_count), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/move_scheduler.md
Name: move_scheduler

Overview:
- Sits between the move sources and the cube-state rotation datapath.
- Accepts move codes from two requesters: the keyboard controller (single-cycle pulses) and the scramble/sequence generator (valid/ready).
- Arbitrates between them into a move queue.
- Issues exactly one move at a time to the rotation datapath, waiting for its completion before issuing the next.

Parameters:
- DEPTH, 8, number of entries in the move queue; must be a power of two, minimum 2.
- MOVE_W, 8, width of a move code (keycode width); code 0 means "no move".

Ports:
- clk  input  1  system clock
- Reset  input  1  asynchronous, active-high reset
- clear  input  1  synchronous queue flush
- key_valid  input  1  one-cycle pulse: key_code is a new move
- key_code  input  MOVE_W  keyboard move code
- key_drop  output  1  one-cycle pulse: a keyboard move was discarded because the queue was full
- seq_valid  input  1  sequence source has a move
- seq_code  input  MOVE_W  sequence move code
- seq_ready  output  1  scheduler accepts seq_code this cycle
- move_f  output  1  one-cycle strobe to the datapath: perform move_code
- move_code  output  MOVE_W  move presented with move_f; 0 otherwise
- rot_done  input  1  one-cycle pulse from the datapath: current move finished
- busy  output  1  a move is in flight (ISSUE or WAIT_DONE)
- q_count  output  $clog2(DEPTH)+1  current queue occupancy
- move_count  output  16  completed moves, wraps 16'hFFFF -> 0

Behaviour:
- Reset is asynchronous, active-high; clock is clk.
- Reset values: move_f=0, move_code=0, key_drop=0, seq_ready=0, busy=0, q_count=0, move_count=0, state=IDLE, queue empty.
- Zero codes: a handshake with code 0 is accepted but not enqueued. No drop pulse is generated.
- Arbitration: keyboard has fixed priority.
  - seq_ready = !full && !key_valid && !clear.
  - A sequence push occurs when seq_valid && seq_ready.
- Keyboard push:
  - If key_valid and not full, key_code is enqueued.
  - If full, the key is discarded and key_drop pulses in the next cycle.
- Full/empty are evaluated on the registered count at the start of the cycle. A push while full is rejected even if a pop happens in the same cycle.
- Push and pop in the same cycle with the queue non-full and non-empty leaves q_count unchanged.
- State machine:
  - IDLE: if queue not empty, pop the head into a hold register and go to ISSUE.
  - ISSUE: move_f=1 and move_code=held code for exactly one cycle, then go to WAIT_DONE.
  - WAIT_DONE: on rot_done, increment move_count and go to IDLE.
- rot_done is sampled only in WAIT_DONE; a pulse in any other state is ignored.
- Issue latency: a move enqueued into an empty queue while IDLE gives move_f 2 cycles after the push cycle (push, pop/IDLE->ISSUE, strobe).
- Back-to-back moves: the minimum gap between move_f strobes is 3 cycles (ISSUE, WAIT_DONE with rot_done in its first cycle, IDLE).
- busy=1 in ISSUE and WAIT_DONE.
- clear:
  - Empties the queue and q_count in the next cycle; pushes in that cycle are ignored (key_drop not pulsed).
  - An in-flight move is not aborted: WAIT_DONE still completes and counts.
  - clear does not reset move_count.
- Queue pointers wrap modulo DEPTH. q_count saturates naturally at DEPTH and never exceeds it.
- Reset asserted mid-move: the move is abandoned with no strobe or count.

Decomposition:
- cube_pkg holds:
  - sched_state_t enum {IDLE, ISSUE, WAIT_DONE}
  - MOVE_NONE = '0
  - MOVE_W default constant
- One sub-module: move_fifo. It is a synchronous FIFO with push, pop, clear, full, empty and count, and the same async Reset. The scheduler owns arbitration and the FSM.

Test Plan:
- Reset, then key_valid with key_code=8'h1D at cycle 0, rot_done 4 cycles after the strobe -> move_f=1 with move_code=8'h1D at cycle 2; busy high cycles 2..6; move_count=1.
- Same-cycle key_valid(8'h15) and seq_valid(8'h2B) -> seq_ready=0 that cycle; issue order is 8'h15 then 8'h2B.
- Stall the datapath (no rot_done) and push 10 keys with DEPTH=8 -> first key in flight, q_count=8; exactly 1 key_drop pulse; remaining 8 codes issued in order after rot_done resumes.
- seq_valid held for 3 moves with key_code=0 pulses interleaved -> zero codes never issued; seq stream issued in order.
- clear asserted during WAIT_DONE with q_count=5 -> q_count=0 next cycle; in-flight move completes on rot_done; move_count increments by 1; no further move_f.
- rot_done pulsed while IDLE, then Reset mid-WAIT_DONE -> move_count unchanged; all outputs return to reset values asynchronously.
